// File: rtl/alu_pkg.sv
// Shared ALU types: function codes, flag bit positions and arbiter FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_INV = 3'd5
  } alu_func_e;

  // Bit positions inside the 4-bit {Z,N,C,V} flag vector.
  typedef enum logic [1:0] {
    FLAG_V = 2'd0,
    FLAG_C = 2'd1,
    FLAG_N = 2'd2,
    FLAG_Z = 2'd3
  } alu_flag_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic func_is_legal(input alu_func_e f);
    logic ok;
    case (f)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_INV: ok = 1'b1;
      default:                                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic func_has_carry(input alu_func_e f);
    logic cy;
    case (f)
      ALU_ADD, ALU_SUB: cy = 1'b1;
      default:          cy = 1'b0;
    endcase
    return cy;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; result bus is tri-stated unless output_enable is high.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_func_e         func_i,
  input  logic              oe_i,
  output tri   [DATA_W-1:0] result_o,
  output logic [3:0]        flags_o
);

  logic [DATA_W:0]   wide_s;
  logic [DATA_W-1:0] res_s;
  logic              c_s;
  logic              v_s;

  // Operation decode; SUB reports borrow in C.
  always_comb begin
    wide_s = {(DATA_W+1){1'b0}};
    res_s  = {DATA_W{1'b0}};
    c_s    = 1'b0;
    v_s    = 1'b0;
    case (func_i)
      ALU_ADD: begin
        wide_s = {1'b0, a_i} + {1'b0, b_i};
        res_s  = wide_s[DATA_W-1:0];
        c_s    = wide_s[DATA_W];
        v_s    = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (res_s[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_SUB: begin
        wide_s = {1'b0, a_i} - {1'b0, b_i};
        res_s  = wide_s[DATA_W-1:0];
        c_s    = wide_s[DATA_W];
        v_s    = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (res_s[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_AND: res_s = a_i & b_i;
      ALU_OR:  res_s = a_i | b_i;
      ALU_XOR: res_s = a_i ^ b_i;
      ALU_INV: res_s = ~a_i;
      default: res_s = {DATA_W{1'b0}};
    endcase
  end

  // Flag packing into {Z,N,C,V}.
  always_comb begin
    flags_o         = 4'b0000;
    flags_o[FLAG_Z] = (res_s == {DATA_W{1'b0}});
    flags_o[FLAG_N] = res_s[DATA_W-1];
    flags_o[FLAG_C] = c_s;
    flags_o[FLAG_V] = v_s;
  end

  assign result_o = oe_i ? res_s : {DATA_W{1'bz}};

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU, one operation in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  alu_func_e         req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  alu_func_e         req1_func,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [3:0]        rsp0_flags,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [3:0]        rsp1_flags,
  output logic              rsp1_err,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  alu_func_e         func_q, func_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] res_q [2];
  logic [DATA_W-1:0] res_d [2];
  logic [3:0]        flags_q [2];
  logic [3:0]        flags_d [2];
  logic [1:0]        err_q, err_d;

  logic [1:0]        req_valid_s, req_ready_s, rsp_ready_s;
  logic              sel_s;
  logic [DATA_W-1:0] alu_a_s, alu_b_s;
  alu_func_e         alu_func_s;
  logic              alu_oe_s;
  wire  [DATA_W-1:0] alu_result_s;
  logic [3:0]        alu_flags_s;
  logic [3:0]        flags_eff_s;

  assign req_valid_s = {req1_valid, req0_valid};
  assign rsp_ready_s = {rsp1_ready, rsp0_ready};

  alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (alu_a_s),
    .b_i      (alu_b_s),
    .func_i   (alu_func_s),
    .oe_i     (alu_oe_s),
    .result_o (alu_result_s),
    .flags_o  (alu_flags_s)
  );

  // Next-state, grant, ALU drive and response-register update.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    func_d      = func_q;
    rsp_valid_d = rsp_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    err_d       = err_q;
    req_ready_s = 2'b00;
    sel_s       = 1'b0;
    alu_a_s     = {DATA_W{1'b0}};
    alu_b_s     = {DATA_W{1'b0}};
    alu_func_s  = ALU_ADD;
    alu_oe_s    = 1'b0;
    flags_eff_s = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_s != 2'b00) begin
          sel_s              = (req_valid_s == 2'b11) ? ptr_q : req_valid_s[1];
          req_ready_s[sel_s] = 1'b1;
          gnt_d              = sel_s;
          a_d                = sel_s ? req1_a : req0_a;
          b_d                = sel_s ? req1_b : req0_b;
          func_d             = sel_s ? req1_func : req0_func;
          state_d            = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Illegal codes never reach the ALU; the bus is only read while enabled.
        if (func_is_legal(func_q)) begin
          alu_a_s     = a_q;
          alu_b_s     = b_q;
          alu_func_s  = func_q;
          alu_oe_s    = 1'b1;
          flags_eff_s = alu_flags_s;
          if (!func_has_carry(func_q)) begin
            flags_eff_s[FLAG_C] = 1'b0;
            flags_eff_s[FLAG_V] = 1'b0;
          end else begin
            flags_eff_s = alu_flags_s;
          end
          res_d[gnt_q]   = alu_result_s;
          flags_d[gnt_q] = flags_eff_s;
          err_d[gnt_q]   = 1'b0;
        end else begin
          res_d[gnt_q]   = {DATA_W{1'b0}};
          flags_d[gnt_q] = 4'b0000;
          err_d[gnt_q]   = 1'b1;
        end
        rsp_valid_d[gnt_q] = 1'b1;
        state_d            = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_s[gnt_q]) begin
          rsp_valid_d[gnt_q] = 1'b0;
          ptr_d              = ~gnt_q;
          state_d            = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      func_q      <= ALU_ADD;
      rsp_valid_q <= 2'b00;
      err_q       <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        res_q[i]   <= {DATA_W{1'b0}};
        flags_q[i] <= 4'b0000;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      func_q      <= func_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      for (int i = 0; i < 2; i++) begin
        res_q[i]   <= res_d[i];
        flags_q[i] <= flags_d[i];
      end
    end
  end

  // Ready is combinational from IDLE, so it is forced low while reset is held.
  assign req0_ready  = req_ready_s[0] & ~rst;
  assign req1_ready  = req_ready_s[1] & ~rst;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = res_q[0];
  assign rsp1_result = res_q[1];
  assign rsp0_flags  = flags_q[0];
  assign rsp1_flags  = flags_q[1];
  assign rsp0_err    = err_q[0];
  assign rsp1_err    = err_q[1];
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed cases, then randomized traffic vs. an arithmetic model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic         err;
    logic [3:0]   flags;
    logic [W-1:0] result;
  } exp_t;

  typedef struct packed {
    logic id;
    exp_t e;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  alu_func_e req0_func, req1_func;
  logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic [3:0] rsp0_flags, rsp1_flags;
  logic rsp0_err, rsp1_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  bit rnd_on;

  ent_t qe[$];
  bit mbusy = 1'b0;
  bit mptr = 1'b0;
  int acc_cyc = 0;
  logic [2:0] mfunc = 3'd0;
  logic [1:0] pv = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, flags {Z,N,C,V}, C is borrow for SUB.
  function automatic exp_t ref_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb, s, r;
    logic c, v;
    exp_t e;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; r = 0;
    e.err = 1'b0; e.flags = 4'd0; e.result = 8'd0;
    case (f)
      3'd0: begin s = ua + ub; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); r = s & 255; end
      3'd1: begin s = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); r = s & 255; end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 255 - ua;
      default: begin e.err = 1'b1; return e; end
    endcase
    e.result = r[7:0];
    e.flags  = {(r == 0), (r > 127), c, v};
    return e;
  endfunction

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    logic [1:0] rdy, vld, rv, rr, er;
    logic [W-1:0] aa[2], bb[2], rs[2];
    logic [3:0] fl[2];
    logic [2:0] ff[2];
    bit acc, hs;
    int who, who_hs;
    ent_t ent;
    rdy = {req1_ready, req0_ready}; vld = {req1_valid, req0_valid};
    rv = {rsp1_valid, rsp0_valid};  rr = {rsp1_ready, rsp0_ready};
    er = {rsp1_err, rsp0_err};
    aa[0] = req0_a; aa[1] = req1_a; bb[0] = req0_b; bb[1] = req1_b;
    ff[0] = req0_func; ff[1] = req1_func;
    rs[0] = rsp0_result; rs[1] = rsp1_result; fl[0] = rsp0_flags; fl[1] = rsp1_flags;
    acc = 1'b0; hs = 1'b0; who = 0; who_hs = 0;
    if (tmo_cnt != tmo_seen) begin
      chk("accept_or_drain_timeout", tmo_cnt, tmo_seen);
      tmo_seen = tmo_cnt;
    end
    if (rst) begin
      chk("reset_outputs", {rdy, rv, busy, er, rsp1_flags, rsp0_flags, rsp1_result, rsp0_result}, 32'd0);
      qe.delete(); mbusy = 1'b0; mptr = 1'b0; pv = 2'b00;
    end else begin
      chk("busy", busy, mbusy);
      chk("alu_oe", dut.alu_oe_s, mbusy && (cyc == acc_cyc + 1) && (mfunc < 3'd6));
      chk("single_ready", (rdy == 2'b11), 1'b0);
      chk("single_rsp", (rv == 2'b11), 1'b0);
      if (!mbusy && vld != 2'b00) chk("grant_when_idle", (rdy != 2'b00), 1'b1);
      for (int i = 0; i < 2; i++) begin
        if (rdy[i]) begin
          chk("ready_while_busy", mbusy, 1'b0);
          chk("ready_without_valid", vld[i], 1'b1);
          if (vld == 2'b11) chk("rr_grant", i, mptr);
          if (vld[i]) begin acc = 1'b1; who = i; end
        end
        if (rv[i]) begin
          chk("rsp_pending", (qe.size() != 0), 1'b1);
          if (qe.size() != 0) begin
            chk("rsp_id", i, qe[0].id);
            chk("rsp_data", {er[i], fl[i], rs[i]}, qe[0].e);
            if (!pv[i]) chk("latency", cyc - acc_cyc, 2);
            if (rr[i]) begin hs = 1'b1; who_hs = i; end
          end
        end
      end
      pv = rv;
      if (hs) begin
        void'(qe.pop_front());
        mbusy = 1'b0;
        mptr = (who_hs == 0);
      end
      if (acc) begin
        ent.id = who[0];
        ent.e = ref_op(ff[who], aa[who], bb[who]);
        qe.push_back(ent);
        mbusy = 1'b1; acc_cyc = cyc; mfunc = ff[who];
      end
    end
  end

  task automatic issue(input bit i, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    bit got;
    got = 1'b0;
    if (i == 1'b0) begin req0_valid = 1'b1; req0_func = alu_func_e'(f); req0_a = a; req0_b = b; end
    else begin req1_valid = 1'b1; req1_func = alu_func_e'(f); req1_a = a; req1_b = b; end
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = (i == 1'b0) ? req0_ready : req1_ready;
    end
    if (!got) tmo_cnt++;
    @(posedge clk); #1;
    if (i == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic rnd_driver(input bit i);
    logic [2:0] f;
    repeat (30) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      f = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      issue(i, f, 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; rnd_on = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    req0_func = ALU_ADD; req1_func = ALU_ADD;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b0, ALU_ADD, 8'hF0, 8'h20);
    issue(1'b1, ALU_SUB, 8'h80, 8'h01);
    issue(1'b1, ALU_SUB, 8'h05, 8'h05);

    // Contention straight out of reset: req0 preferred, then alternation.
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fork
      issue(1'b0, ALU_AND, 8'hFF, 8'h0F);
      issue(1'b1, ALU_XOR, 8'hAA, 8'hFF);
    join
    fork
      issue(1'b0, ALU_OR, 8'h3C, 8'h41);
      issue(1'b1, ALU_INV, 8'h5A, 8'h00);
    join

    // Response back-pressure while the other requester waits.
    rsp0_ready = 1'b0;
    issue(1'b0, ALU_ADD, 8'h7F, 8'h01);
    fork
      issue(1'b1, ALU_SUB, 8'h10, 8'h20);
      begin repeat (6) @(posedge clk); #1 rsp0_ready = 1'b1; end
    join

    // Reset while the operation is in EXEC.
    issue(1'b0, ALU_ADD, 8'h03, 8'h04);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    issue(1'b0, ALU_SUB, 8'h09, 8'h03);

    issue(1'b0, 3'd6, 8'h11, 8'h22);
    issue(1'b1, 3'd7, 8'h33, 8'h44);

    rnd_on = 1'b1;
    fork
      begin
        fork
          rnd_driver(1'b0);
          rnd_driver(1'b1);
        join
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          rsp0_ready = 1'($urandom_range(0, 1));
          rsp1_ready = 1'($urandom_range(0, 1));
        end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      end
    join

    for (int k = 0; k < 100 && (qe.size() != 0 || busy); k++) @(negedge clk);
    if (qe.size() != 0 || busy) tmo_cnt++;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the operand/result width, passed to the ALU.
REQ-002 SHALL have ports clk input 1 (single clock) and rst input 1 (asynchronous, active-high reset).
REQ-003 SHALL have, for each requester i in {0,1}: req<i>_valid input 1, req<i>_ready output 1, req<i>_a input DATA_W, req<i>_b input DATA_W, req<i>_func input alu_func_e.
REQ-004 SHALL have, for each i: rsp<i>_valid output 1, rsp<i>_ready input 1, rsp<i>_result output DATA_W, rsp<i>_flags output 4 ({Z,N,C,V}), rsp<i>_err output 1.
REQ-005 SHALL have busy output 1, high whenever the FSM is not IDLE.

Function
REQ-006 SHALL implement a 3-state FSM: IDLE, EXEC, RESP; one operation outstanding at a time.
REQ-007 In IDLE, if any req<i>_valid is high, SHALL assert req<i>_ready for exactly one granted requester in that cycle, capture its a/b/func/id, and move to EXEC.
REQ-008 req<i>_ready SHALL be low in EXEC and RESP, and low for the non-granted requester.
REQ-009 Grant SHALL be round-robin: a 1-bit priority pointer selects the preferred requester when both are valid; the pointer SHALL flip to the other requester after each completed response handshake.
REQ-010 In EXEC, SHALL drive the ALU with the captured operands and func and output_enable=1, register result and Z/N/C/V into the granted requester's response registers, and move to RESP.
REQ-011 C and V SHALL be stored from the ALU only for ADD/SUB; for AND/OR/XOR/INV they SHALL be stored as 0.
REQ-012 SHALL drive the ALU output_enable=0 and func=ADD with operands 0 in IDLE and RESP, so the ALU never sees an X or illegal func.
REQ-013 A captured func outside {ADD,SUB,AND,OR,XOR,INV} SHALL NOT be driven to the ALU; the block SHALL skip ALU use, set rsp_err=1, result=0, flags=0.
REQ-014 In RESP, rsp<g>_valid SHALL be high for the granted requester only, holding result/flags/err stable until rsp<g>_ready is high; on that cycle SHALL return to IDLE.
REQ-015 Latency: request accepted in cycle T, rsp_valid high from cycle T+2; one new accept at most every 3 cycles with rsp_ready tied high.
REQ-016 A requester SHALL be able to present a new request while its previous response is pending; it SHALL NOT be granted until IDLE.
REQ-017 rsp_ready while rsp_valid is low SHALL be ignored.

Reset
REQ-018 On rst high, asynchronously: FSM=IDLE, pointer=0 (requester 0 preferred), all req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, busy=0.
REQ-019 Reset in EXEC or RESP SHALL abandon the operation; no response for it SHALL appear after reset release.

Structure
REQ-020 alu_func_e SHALL come from alu_pkg; a flag-bit index enum (FLAG_Z..FLAG_V) and the FSM state enum SHALL be added to alu_pkg.
REQ-021 SHALL instantiate exactly one alu sub-module; its tri-state result SHALL be read only while output_enable=1.
REQ-022 Estimated 150-250 lines RTL.

Verification
REQ-023 req0 ADD a=0xF0 b=0x20 -> rsp0_valid at T+2, result 0x10, flags Z=0 N=0 C=1 V=0.
REQ-024 req1 SUB a=0x80 b=0x01 -> result 0x7F, N=0 C=0 V=1; then SUB 0x05-0x05 -> result 0x00, Z=1.
REQ-025 After reset, both valid same cycle (req0 AND 0xFF&0x0F, req1 XOR 0xAA^0xFF) -> req0 granted first (0x0F), req1 next (0x55, N=0), pointer then back to req0.
REQ-026 rsp0_ready held low 4 cycles in RESP -> rsp0_valid and data stable, req_ready low, busy=1; accept resumes only after handshake.
REQ-027 rst asserted during EXEC -> all outputs at reset values immediately; no rsp_valid after release; next request completes normally.
REQ-028 req0 with illegal func encoding -> rsp0_err=1, result 0x00, flags 0, ALU output_enable never asserted, no fatal.
